// File: rtl/cursor_motion_ctrl_pkg.sv
// cursor_pkg: shared constants, FSM state type and arithmetic helpers for
// the cursor motion controller.
//   SCREEN_W_C / SCREEN_H_C : visible screen size in pixels
//   ACC_W                   : motion accumulator width (signed)
//   POS_W                   : committed position width (unsigned)
//   sat_add()               : signed add saturating at ACC_W bits
//   clamp()                 : clamp an (ACC_W+1)-bit signed value into [lo, hi]
package cursor_pkg;
  localparam int SCREEN_W_C = 640;
  localparam int SCREEN_H_C = 480;
  localparam int ACC_W      = 12;
  localparam int POS_W      = 10;

  typedef enum logic {ACCUM = 1'b0, COMMIT = 1'b1} cursor_state_t;

  localparam logic signed [ACC_W:0] SUM_MAX = 13'sd2047;
  localparam logic signed [ACC_W:0] SUM_MIN = -13'sd2048;

  // One guard bit is enough to see any overflow of an ACC_W-bit add.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + $signed({b[ACC_W-1], b});
    if (s > SUM_MAX)      return SUM_MAX[ACC_W-1:0];
    else if (s < SUM_MIN) return SUM_MIN[ACC_W-1:0];
    else                  return s[ACC_W-1:0];
  endfunction

  function automatic logic [POS_W-1:0] clamp(
    input logic signed [ACC_W:0] v,
    input logic signed [ACC_W:0] lo,
    input logic signed [ACC_W:0] hi
  );
    if (v < lo)      return lo[POS_W-1:0];
    else if (v > hi) return hi[POS_W-1:0];
    else             return v[POS_W-1:0];
  endfunction
endpackage

// File: rtl/cursor_motion_ctrl_if.sv
// Motion packet handshake (PS/2 mouse style relative motion).
//   pkt_valid : source has a packet
//   pkt_ready : sink accepts this cycle
//   pkt_dx    : signed X delta, +right
//   pkt_dy    : signed Y delta, +up
//   pkt_btn   : left-button state
// master = packet source, slave = cursor controller.
interface cursor_motion_ctrl_if;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [8:0] pkt_dx;
  logic [8:0] pkt_dy;
  logic       pkt_btn;

  modport master (output pkt_valid, pkt_dx, pkt_dy, pkt_btn, input pkt_ready);
  modport slave  (input pkt_valid, pkt_dx, pkt_dy, pkt_btn, output pkt_ready);
endinterface

// File: rtl/cursor_motion_ctrl_frame_edge_sync.sv
// frame_edge_sync: brings an asynchronous frame strobe into the clk domain
// and emits a one-cycle pulse on its rising edge. Shared by frame-rate blocks.
//   clk        : destination clock
//   reset      : synchronous, active-high
//   async_in   : asynchronous strobe
//   edge_pulse : one-cycle pulse per rising edge of async_in
module frame_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 & ~s3;
endmodule

// File: rtl/cursor_motion_ctrl.sv
// cursor_motion_ctrl: accumulates relative motion packets between frames and
// commits them to clamped absolute cursor coordinates once per frame strobe.
//   Clk, Reset      : system clock, synchronous active-high reset
//   frame_clk       : asynchronous frame strobe
//   pkt             : motion packet handshake (slave side)
//   cursorX/cursorY : committed position, stable between commits
//   click_pulse     : one cycle, button press seen during the last frame
//   moved           : one cycle, committed position changed
module cursor_motion_ctrl
  import cursor_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_C,
  parameter int SCREEN_H = SCREEN_H_C,
  parameter int INIT_X   = 320,
  parameter int INIT_Y   = 240,
  parameter int MARGIN   = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  cursor_motion_ctrl_if.slave   pkt,
  output logic [POS_W-1:0]      cursorX,
  output logic [POS_W-1:0]      cursorY,
  output logic                  click_pulse,
  output logic                  moved
);
  localparam logic signed [ACC_W:0] X_LO = (ACC_W+1)'(MARGIN);
  localparam logic signed [ACC_W:0] X_HI = (ACC_W+1)'(SCREEN_W - 1 - MARGIN);
  localparam logic signed [ACC_W:0] Y_LO = (ACC_W+1)'(MARGIN);
  localparam logic signed [ACC_W:0] Y_HI = (ACC_W+1)'(SCREEN_H - 1 - MARGIN);

  cursor_state_t state, state_nxt;
  logic          frame_edge;
  logic          do_commit;
  logic          accept;

  logic signed [ACC_W-1:0] acc_x, acc_y;
  logic signed [ACC_W-1:0] dx_ext, dy_neg;
  logic signed [ACC_W:0]   nx_w, ny_w;
  logic [POS_W-1:0]        nx, ny;
  logic                    last_btn, pend_click;

  frame_edge_sync u_sync (
    .clk       (Clk),
    .reset     (Reset),
    .async_in  (frame_clk),
    .edge_pulse(frame_edge)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (frame_edge) state_nxt = COMMIT;
      COMMIT:  state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Ready is masked by Reset so nothing is consumed during the reset cycle.
  always_comb begin
    pkt.pkt_ready = 1'b0;
    do_commit     = 1'b0;
    case (state)
      ACCUM:   pkt.pkt_ready = ~Reset;
      COMMIT:  do_commit     = 1'b1;
      default: ;
    endcase
  end

  assign accept = pkt.pkt_valid & pkt.pkt_ready;

  // Screen Y grows downward while PS/2 dy is +up, so dy is subtracted.
  assign dx_ext = $signed({{(ACC_W-9){pkt.pkt_dx[8]}}, pkt.pkt_dx});
  assign dy_neg = -$signed({{(ACC_W-9){pkt.pkt_dy[8]}}, pkt.pkt_dy});

  assign nx_w = $signed({{(ACC_W+1-POS_W){1'b0}}, cursorX}) + $signed({acc_x[ACC_W-1], acc_x});
  assign ny_w = $signed({{(ACC_W+1-POS_W){1'b0}}, cursorY}) + $signed({acc_y[ACC_W-1], acc_y});
  assign nx   = clamp(nx_w, X_LO, X_HI);
  assign ny   = clamp(ny_w, Y_LO, Y_HI);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cursorX     <= POS_W'(INIT_X);
      cursorY     <= POS_W'(INIT_Y);
      acc_x       <= '0;
      acc_y       <= '0;
      last_btn    <= 1'b0;
      pend_click  <= 1'b0;
      click_pulse <= 1'b0;
      moved       <= 1'b0;
    end else begin
      click_pulse <= 1'b0;
      moved       <= 1'b0;
      if (do_commit) begin
        cursorX     <= nx;
        cursorY     <= ny;
        acc_x       <= '0;
        acc_y       <= '0;
        moved       <= (nx != cursorX) || (ny != cursorY);
        click_pulse <= pend_click;
        pend_click  <= 1'b0;
      end else if (accept) begin
        acc_x    <= sat_add(acc_x, dx_ext);
        acc_y    <= sat_add(acc_y, dy_neg);
        last_btn <= pkt.pkt_btn;
        if (pkt.pkt_btn && !last_btn) pend_click <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cursor_motion_ctrl.sv
// Directed bench for cursor_motion_ctrl. Expected commits are queued when a
// frame is launched and checked when the DUT pulses `moved`.
module tb_cursor_motion_ctrl;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] cursorX, cursorY;
  logic       click_pulse, moved;

  cursor_motion_ctrl_if pif ();

  cursor_motion_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .pkt        (pif),
    .cursorX    (cursorX),
    .cursorY    (cursorY),
    .click_pulse(click_pulse),
    .moved      (moved)
  );

  always #5 Clk = ~Clk;

  typedef struct {int x; int y; int clk;} exp_t;
  exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every `moved` pulse must match the oldest queued commit.
  initial begin : monitor
    bit   prev_mv, prev_clk;
    exp_t e;
    prev_mv  = 1'b0;
    prev_clk = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        if (prev_mv)  chk("moved_width", int'(moved), 0);
        if (prev_clk) chk("click_width", int'(click_pulse), 0);
        if (moved) begin
          if (q.size() == 0) chk("unexpected_move", int'(moved), 0);
          else begin
            e = q.pop_front();
            chk("cursorX", int'(cursorX), e.x);
            chk("cursorY", int'(cursorY), e.y);
            chk("click_pulse", int'(click_pulse), e.clk);
          end
        end
      end
      prev_mv  = moved && !Reset;
      prev_clk = click_pulse && !Reset;
    end
  end

  task automatic send(input int dx, input int dy, input int btn);
    @(negedge Clk);
    pif.pkt_valid = 1'b1;
    pif.pkt_dx    = 9'(dx);
    pif.pkt_dy    = 9'(dy);
    pif.pkt_btn   = 1'(btn);
    for (int i = 0; i < 20 && !pif.pkt_ready; i++) @(negedge Clk);
    chk("send_ready", int'(pif.pkt_ready), 1);
    @(posedge Clk);
  endtask

  task automatic idle();
    @(negedge Clk);
    pif.pkt_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge Clk);
    chk("drain", q.size(), 0);
  endtask

  task automatic wait_commit();
    for (int i = 0; i < 12 && pif.pkt_ready; i++) @(negedge Clk);
    chk("commit_ready", int'(pif.pkt_ready), 0);
  endtask

  task automatic frame(input int x, input int y, input int c);
    exp_t e;
    e.x = x; e.y = y; e.clk = c;
    q.push_back(e);
    @(negedge Clk);
    frame_clk = 1'b1;
    wait_drain();
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("reset_ready", int'(pif.pkt_ready), 0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("rst_cursorX", int'(cursorX), 320);
    chk("rst_cursorY", int'(cursorY), 240);
    chk("rst_click", int'(click_pulse), 0);
    chk("rst_moved", int'(moved), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    pif.pkt_valid = 1'b0;
    pif.pkt_dx    = '0;
    pif.pkt_dy    = '0;
    pif.pkt_btn   = 1'b0;
    do_reset();

    // basic move: +right 10, +up 5
    send(10, 5, 0); idle();
    frame(330, 235, 0);

    // X clamping at both edges
    do_reset();
    repeat (3) send(255, 0, 0);
    idle();
    frame(635, 240, 0);
    repeat (3) send(-256, 0, 0);
    idle();
    frame(4, 240, 0);

    // Y accumulator saturation (wrap would land at the top margin)
    repeat (10) send(0, -255, 0);
    idle();
    frame(4, 475, 0);

    // packet presented during COMMIT belongs to the next frame
    send(1, 0, 0); idle();
    begin
      exp_t e;
      e.x = 5; e.y = 475; e.clk = 0;
      q.push_back(e);
    end
    @(negedge Clk);
    frame_clk = 1'b1;
    wait_commit();
    pif.pkt_valid = 1'b1;
    pif.pkt_dx    = 9'(2);
    pif.pkt_dy    = '0;
    pif.pkt_btn   = 1'b0;
    frame_clk     = 1'b0;
    @(negedge Clk);
    chk("ready_after_commit", int'(pif.pkt_ready), 1);
    @(negedge Clk);
    pif.pkt_valid = 1'b0;
    wait_drain();
    repeat (3) @(negedge Clk);
    frame(7, 475, 0);

    // button 0->1->1 gives one click; held button gives none
    send(1, 0, 0); send(1, 0, 1); send(1, 0, 1); idle();
    frame(10, 475, 1);
    send(1, 0, 1); idle();
    frame(11, 475, 0);

    // reset during COMMIT: no commit, no pulse, pending click discarded
    send(1, 0, 0); send(1, 0, 1); idle();
    @(negedge Clk);
    frame_clk = 1'b1;
    wait_commit();
    Reset     = 1'b1;
    frame_clk = 1'b0;
    @(negedge Clk);
    chk("midrst_cursorX", int'(cursorX), 320);
    chk("midrst_cursorY", int'(cursorY), 240);
    chk("midrst_moved", int'(moved), 0);
    chk("midrst_click", int'(click_pulse), 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    send(1, 0, 0); idle();
    frame(321, 240, 0);

    repeat (4) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
